// File: rtl/dice_datapath.sv
// Dice generator and classifier: free-running 6x6 counters, captured on a roll rising edge, then summed and flagged.
// Latency: die values at the capture edge, sum/flags/sum_valid one edge later; eq/seven_out are combinational.
// Backpressure: none; every roll edge flows through the two-stage pipe and no roll is dropped.
module dice_datapath #(
    parameter int D1_INIT = 1,
    parameter int D2_INIT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk_main,
    input  logic             reset,
    input  logic             roll,
    input  logic             sp,
    output logic [2:0]       die1,
    output logic [2:0]       die2,
    output logic [3:0]       sum,
    output logic [3:0]       point,
    output logic             sum_valid,
    output logic             natural,
    output logic             craps,
    output logic             eq,
    output logic             seven_out,
    output logic [CNT_W-1:0] roll_count
);

    logic [2:0]       d1_ctr_q, d1_ctr_d;
    logic [2:0]       d2_ctr_q, d2_ctr_d;
    logic             roll_q;
    logic             roll_rise;
    logic [2:0]       die1_q, die1_d;
    logic [2:0]       die2_q, die2_d;
    logic             cap_v_q, cap_v_d;
    logic [3:0]       sum_q, sum_d;
    logic [3:0]       sum_new;
    logic             natural_q, natural_d;
    logic             craps_q, craps_d;
    logic             sum_valid_q, sum_valid_d;
    logic             have_sum_q, have_sum_d;
    logic [CNT_W-1:0] roll_count_q, roll_count_d;
    logic [3:0]       point_q, point_d;
    logic             point_valid_q, point_valid_d;

    assign roll_rise = roll & ~roll_q;
    assign sum_new   = {1'b0, die1_q} + {1'b0, die2_q};

    always_comb begin
        // Die 2 steps only when die 1 wraps, giving all 36 pairs with period 36.
        d1_ctr_d = (d1_ctr_q == 3'd6) ? 3'd1 : d1_ctr_q + 3'd1;
        d2_ctr_d = d2_ctr_q;
        if (d1_ctr_q == 3'd6) begin
            d2_ctr_d = (d2_ctr_q == 3'd6) ? 3'd1 : d2_ctr_q + 3'd1;
        end

        die1_d  = die1_q;
        die2_d  = die2_q;
        cap_v_d = roll_rise;
        if (roll_rise) begin
            die1_d = d1_ctr_q;
            die2_d = d2_ctr_q;
        end

        sum_d        = sum_q;
        natural_d    = natural_q;
        craps_d      = craps_q;
        have_sum_d   = have_sum_q;
        roll_count_d = roll_count_q;
        sum_valid_d  = cap_v_q;
        if (cap_v_q) begin
            sum_d      = sum_new;
            natural_d  = (sum_new == 4'd7) || (sum_new == 4'd11);
            craps_d    = (sum_new == 4'd2) || (sum_new == 4'd3) || (sum_new == 4'd12);
            have_sum_d = 1'b1;
            if (roll_count_q != {CNT_W{1'b1}}) begin
                roll_count_d = roll_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end

        // Loads the sum as registered this cycle, so a coincident classify lands one cycle later.
        point_d       = point_q;
        point_valid_d = point_valid_q;
        if (sp && have_sum_q) begin
            point_d       = sum_q;
            point_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            d1_ctr_q      <= 3'(D1_INIT);
            d2_ctr_q      <= 3'(D2_INIT);
            roll_q        <= 1'b0;
            die1_q        <= 3'd0;
            die2_q        <= 3'd0;
            cap_v_q       <= 1'b0;
            sum_q         <= 4'd0;
            natural_q     <= 1'b0;
            craps_q       <= 1'b0;
            sum_valid_q   <= 1'b0;
            have_sum_q    <= 1'b0;
            roll_count_q  <= '0;
            point_q       <= 4'd0;
            point_valid_q <= 1'b0;
        end else begin
            d1_ctr_q      <= d1_ctr_d;
            d2_ctr_q      <= d2_ctr_d;
            roll_q        <= roll;
            die1_q        <= die1_d;
            die2_q        <= die2_d;
            cap_v_q       <= cap_v_d;
            sum_q         <= sum_d;
            natural_q     <= natural_d;
            craps_q       <= craps_d;
            sum_valid_q   <= sum_valid_d;
            have_sum_q    <= have_sum_d;
            roll_count_q  <= roll_count_d;
            point_q       <= point_d;
            point_valid_q <= point_valid_d;
        end
    end

    assign die1       = die1_q;
    assign die2       = die2_q;
    assign sum        = sum_q;
    assign point      = point_q;
    assign sum_valid  = sum_valid_q;
    assign natural    = natural_q;
    assign craps      = craps_q;
    assign roll_count = roll_count_q;
    // Both may assert when point is 7; the controller resolves that case.
    assign eq         = point_valid_q && (sum_q == point_q);
    assign seven_out  = point_valid_q && (sum_q == 4'd7);

endmodule

// File: tb/tb_dice_datapath.sv
// Directed bench for dice_datapath: rolls are timed against an edge count since reset release.
module tb_dice_datapath;

    logic       clk_main;
    logic       reset;
    logic       roll;
    logic       sp;
    logic [2:0] die1, die2;
    logic [3:0] sum, point;
    logic       sum_valid, natural, craps, eq, seven_out;
    logic [7:0] roll_count;

    int unsigned n_chk;
    int unsigned n_pass;
    int unsigned exp_cnt;
    int unsigned ecount;

    dice_datapath #(.D1_INIT(1), .D2_INIT(1), .CNT_W(8)) dut (
        .clk_main   (clk_main),
        .reset      (reset),
        .roll       (roll),
        .sp         (sp),
        .die1       (die1),
        .die2       (die2),
        .sum        (sum),
        .point      (point),
        .sum_valid  (sum_valid),
        .natural    (natural),
        .craps      (craps),
        .eq         (eq),
        .seven_out  (seven_out),
        .roll_count (roll_count)
    );

    initial clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    // Index of the next rising edge since reset release (valid when read at a falling edge).
    always @(posedge clk_main or negedge reset) begin
        if (!reset) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk_main);
        reset = 1'b0;
        repeat (2) @(negedge clk_main);
        reset   = 1'b1;
        exp_cnt = 0;
    endtask

    // Raise roll for exactly the edge at which the counters show (a, b), then check both stages.
    task automatic roll_dice(input int unsigned a, input int unsigned b,
                             input int unsigned exp_nat, input int unsigned exp_crp);
        int unsigned idx;
        bit found;
        idx   = (b - 1) * 6 + (a - 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((ecount % 36) == idx) found = 1;
            else @(negedge clk_main);
        end
        if (!found) begin
            chk("roll_timeout", 0, 1);
            return;
        end
        roll = 1'b1;
        @(negedge clk_main);
        roll = 1'b0;
        chk("die1", die1, a);
        chk("die2", die2, b);
        chk("sv_early", sum_valid, 0);
        @(negedge clk_main);
        if (exp_cnt < 255) exp_cnt++;
        chk("sum", sum, a + b);
        chk("natural", natural, exp_nat);
        chk("craps", craps, exp_crp);
        chk("sum_valid", sum_valid, 1);
        chk("roll_count", roll_count, exp_cnt);
    endtask

    initial begin
        int unsigned pulses;
        n_chk   = 0;
        n_pass  = 0;
        exp_cnt = 0;
        reset   = 1'b0;
        roll    = 1'b0;
        sp      = 1'b0;
        do_reset();

        // Reset pulsed while a capture is in flight.
        @(negedge clk_main);
        roll = 1'b1;
        @(posedge clk_main);
        #1 reset = 1'b0;
        #1;
        chk("rst_die1", die1, 0);
        chk("rst_die2", die2, 0);
        chk("rst_sum", sum, 0);
        chk("rst_point", point, 0);
        chk("rst_flags", {sum_valid, natural, craps, eq, seven_out}, 0);
        chk("rst_count", roll_count, 0);
        @(negedge clk_main);
        roll = 1'b0;
        @(negedge clk_main);
        reset   = 1'b1;
        exp_cnt = 0;
        // Capture at edge 0 after release: counters back at 1,1, and no stale sum_valid.
        roll_dice(1, 1, 0, 1);

        // Fresh reset: edge 5 after release shows 6,1.
        do_reset();
        roll_dice(6, 1, 1, 0);
        chk("point_idle", point, 0);
        chk("eq_idle", eq, 0);
        roll_dice(6, 6, 0, 1);

        // Point load and eq / seven_out.
        roll_dice(3, 1, 0, 0);
        sp = 1'b1;
        @(negedge clk_main);
        sp = 1'b0;
        chk("point4", point, 4);
        chk("eq4", eq, 1);
        chk("so4", seven_out, 0);
        roll_dice(6, 1, 1, 0);
        chk("so7", seven_out, 1);
        chk("eq7", eq, 0);
        chk("point_hold", point, 4);
        roll_dice(3, 1, 0, 0);
        chk("eq4b", eq, 1);
        chk("so4b", seven_out, 0);
        chk("point4b", point, 4);

        // sp coincident with classify loads the old sum, then the new one.
        roll_dice(2, 1, 0, 1);
        sp = 1'b1;
        roll_dice(4, 2, 0, 0);
        chk("point_old", point, 3);
        chk("eq_old", eq, 0);
        @(negedge clk_main);
        sp = 1'b0;
        chk("point_new", point, 6);
        chk("eq_new", eq, 1);

        // Roll held high for 20 cycles yields one capture.
        pulses = 0;
        roll   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_main);
            if (sum_valid) pulses++;
        end
        roll = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_main);
            if (sum_valid) pulses++;
        end
        exp_cnt++;
        chk("held_pulses", pulses, 1);
        chk("held_count", roll_count, exp_cnt);

        // 259 back-to-back rolls, two cycles apart: none dropped, counter saturates.
        pulses = 0;
        for (int i = 0; i < 259; i++) begin
            roll = 1'b1;
            @(negedge clk_main);
            if (sum_valid) pulses++;
            roll = 1'b0;
            @(negedge clk_main);
            if (sum_valid) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_main);
            if (sum_valid) pulses++;
        end
        chk("sat_pulses", pulses, 259);
        chk("sat_count", roll_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dice_datapath.md
# dice_datapath

Dice-generation and classification stage that sits directly upstream of the craps game controller. It runs two free-running die counters and captures them on each rising edge of the controller's `roll` strobe. It then produces a registered sum and the four classification flags the controller consumes: `natural`, `craps`, `eq` and `seven_out`. It also holds the point register loaded under the controller's `sp` enable, and exports die, sum and point values for display.

## Interface

Parameters:
- `D1_INIT`, default 1: reset value of die 1 counter (legal 1..6).
- `D2_INIT`, default 1: reset value of die 2 counter (legal 1..6).
- `CNT_W`, default 8: width of the roll counter.

Ports:
- `clk_main`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `roll`  in  1  roll strobe from controller; level input, action on rising edge.
- `sp`  in  1  point-register load enable from controller.
- `die1`  out  3  captured die 1 value, 1..6.
- `die2`  out  3  captured die 2 value, 1..6.
- `sum`  out  4  registered die1+die2, 2..12.
- `point`  out  4  stored point value.
- `sum_valid`  out  1  one-cycle pulse when new `sum` and flags are valid.
- `natural`  out  1  `sum` is 7 or 11.
- `craps`  out  1  `sum` is 2, 3 or 12.
- `eq`  out  1  `point_valid` and `sum == point`.
- `seven_out`  out  1  `point_valid` and `sum == 7`.
- `roll_count`  out  CNT_W  number of completed rolls, saturating.

## Operation

- Free-running dice:
  - `d1_ctr` advances 1→2→…→6→1 every cycle.
  - `d2_ctr` advances by one only on cycles where `d1_ctr` wraps 6→1.
  - Together they cycle through all 36 combinations with period 36.
- Edge detect: `roll_q` holds `roll` delayed one cycle. `roll_rise = roll & ~roll_q`.
- Stage 1, capture: on `roll_rise`, `die1 <= d1_ctr`, `die2 <= d2_ctr`, and internal `cap_v` is set for one cycle.
- Stage 2, classify: when `cap_v` is set:
  - `sum <= die1 + die2` (4-bit; no overflow, max 12).
  - `natural`, `craps`, `sum_valid` and `have_sum` are registered from the new sum.
  - `roll_count` increments, saturating at all-ones.
- Flag hold: `natural`, `craps`, `sum` and `die*` hold until the next classify. `sum_valid` is high for exactly one cycle per roll.
- Point register:
  - Each cycle with `sp == 1` and `have_sum == 1`: `point <= sum` and `point_valid <= 1`.
  - The register retains its value while `sp == 0`.
  - `point_valid` clears only on reset.
- `eq` and `seven_out` are combinational from the `sum`, `point` and `point_valid` registers. Both may be 1 together only if point is 7; the controller treats that as `seven_out` (decoded `2'b11` → default). The block does not arbitrate.
- Roll spacing: a new rising edge needs at least one low cycle, so edges are ≥2 cycles apart. Back-to-back edges each flow through the 2-stage pipe independently and no roll is dropped.
- `sp` and `cap_v` in the same cycle: `point` loads the old `sum`. The new sum is loaded on the next cycle if `sp` is still high.

## Timing

- Reset values (asynchronous, while `reset == 0`):
  - `die1 = die2 = 0`, `sum = 0`, `point = 0`.
  - All flags, `sum_valid`, `point_valid`, `have_sum` and `roll_q` = 0.
  - `roll_count = 0`; `d1_ctr = D1_INIT`, `d2_ctr = D2_INIT`.
- Latency:
  - `roll` seen high at edge N with `roll_q` low → `die*` updated at edge N.
  - `sum`, `natural`, `craps` and `sum_valid` are updated at edge N+1.
  - `eq` and `seven_out` are valid after edge N+1.
- Point: `sp` high at edge M with `have_sum` → `point` updated at edge M; `eq` reflects it after edge M.
- Reset mid-pipeline: any in-flight capture is discarded and no `sum_valid` is issued after release.
- `roll` held high continuously produces exactly one capture.

## Test plan

- Reset: pulse `reset` low during a roll → all outputs 0. After release, `d1_ctr = 1` and `d2_ctr = 1`; no `sum_valid` pulse.
- Counter sequence: release reset, then raise `roll` at cycle 5 after release → `die1 = 6`, `die2 = 1`. One cycle later: `sum = 7`, `natural = 1`, `craps = 0`, `sum_valid` one cycle, `roll_count = 1`.
- Craps: capture at cycle 0 after release (1+1) → `sum = 2`, `craps = 1`, `natural = 0`. At cycle 35 (6+6) → `sum = 12`, `craps = 1`.
- Point and eq: roll sum 4 with `sp = 1` → `point = 4`, `eq = 1`. Drop `sp`, roll sum 7 → `seven_out = 1`, `eq = 0`. Roll sum 4 again → `eq = 1`, `point` still 4.
- Held roll: hold `roll` high for 20 cycles → exactly one `sum_valid` pulse, `roll_count` +1.
- Saturation: perform 2^CNT_W + 3 rolls → `roll_count` = all-ones.
